// File: rtl/buffer_read_arbiter.sv
// Read-port arbiter for the shared integral-image buffer: round-robin with capped lock bursts,
// plus a tag pipeline that marks which requester owns each returning read.
module buffer_read_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_W     = 15,
    parameter int unsigned DATA_W     = 21,
    parameter int unsigned RD_LATENCY = 3,
    parameter int unsigned MAX_LOCK   = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [N_REQ-1:0]           req_i,
    input  logic [N_REQ-1:0]           lock_i,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr_i,
    output logic [N_REQ-1:0]           gnt_o,
    output logic [ADDR_W-1:0]          buf_rd_addr_o,
    input  logic signed [DATA_W-1:0]   buf_rd_data_i,
    output logic signed [DATA_W-1:0]   rd_data_o,
    output logic [N_REQ-1:0]           rd_valid_o,
    output logic                       busy_o
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_LOCK + 1);

    logic [IdxW-1:0]   last_q, last_d;
    logic [CntW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [N_REQ-1:0]  tag_q [RD_LATENCY];
    logic              locked;
    logic              found;
    logic [IdxW-1:0]   idx;

    always_comb begin
        gnt_d      = '0;
        last_d     = last_q;
        lock_cnt_d = '0;
        addr_d     = addr_q;
        found      = 1'b0;
        idx        = '0;
        // The counter holds locked grants after the first one, so the whole burst is MAX_LOCK.
        locked = gnt_q[last_q] && req_i[last_q] && lock_i[last_q] &&
                 (lock_cnt_q < CntW'(MAX_LOCK - 1));
        if (locked) begin
            gnt_d[last_q] = 1'b1;
            lock_cnt_d    = lock_cnt_q + 1'b1;
            found         = 1'b1;
        end else begin
            for (int unsigned i = 1; i <= N_REQ; i++) begin
                idx = IdxW'((32'(last_q) + i) % N_REQ);
                if (!found && req_i[idx]) begin
                    found       = 1'b1;
                    gnt_d[idx]  = 1'b1;
                    last_d      = idx;
                end
            end
        end
        if (found) begin
            addr_d = req_addr_i[last_d*ADDR_W +: ADDR_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q     <= IdxW'(N_REQ - 1);
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            last_q     <= last_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            tag_q[0]   <= gnt_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    always_comb begin
        busy_o = |gnt_q;
        for (int i = 0; i < RD_LATENCY; i++) begin
            busy_o = busy_o | (|tag_q[i]);
        end
    end

    assign gnt_o         = gnt_q;
    assign buf_rd_addr_o = addr_q;
    assign rd_valid_o    = tag_q[RD_LATENCY-1];
    assign rd_data_o     = buf_rd_data_i;

endmodule

// File: tb/tb_buffer_read_arbiter.sv
// Bench for buffer_read_arbiter: buffer model with fixed latency, a behavioural arbiter model
// checked every cycle, and directed scenarios with literal expectations.
module tb_buffer_read_arbiter;

    localparam int N  = 4;
    localparam int AW = 15;
    localparam int DW = 21;
    localparam int L  = 3;
    localparam int ML = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N-1:0]         lock = '0;
    logic [N*AW-1:0]      req_addr = '0;
    logic [N-1:0]         gnt;
    logic [AW-1:0]        buf_rd_addr;
    logic signed [DW-1:0] buf_rd_data;
    logic signed [DW-1:0] rd_data;
    logic [N-1:0]         rd_valid;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    buffer_read_arbiter #(
        .N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(L), .MAX_LOCK(ML)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .lock_i(lock), .req_addr_i(req_addr),
        .gnt_o(gnt), .buf_rd_addr_o(buf_rd_addr), .buf_rd_data_i(buf_rd_data),
        .rd_data_o(rd_data), .rd_valid_o(rd_valid), .busy_o(busy)
    );

    function automatic logic signed [DW-1:0] f(input int a);
        return DW'(a * 3 - 5000);
    endfunction

    function automatic logic [N-1:0] oh(input int i);
        return (i >= 0) ? (N'(1) << i) : '0;
    endfunction

    function automatic int oh2i(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v == oh(i)) return i;
        return -1;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Buffer: data for an address appears L cycles after the address register updates.
    logic [AW-1:0] hist [L];
    always @(posedge clk) begin
        hist[0] <= buf_rd_addr;
        for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
    end
    assign buf_rd_data = f(int'(hist[L-1]));

    // Behavioural model: -1 means no grant.
    typedef struct { int who; int addr; } ent_t;
    int   m_gnt, m_last, m_run, m_addr;
    ent_t mp [L];

    always @(posedge clk or negedge rst_n) begin : model_blk
        int g, idx;
        bit lk;
        if (!rst_n) begin
            m_gnt  <= -1;
            m_last <= N - 1;
            m_run  <= 0;
            m_addr <= 0;
            for (int i = 0; i < L; i++) mp[i] <= '{-1, 0};
        end else begin
            g  = -1;
            lk = 1'b0;
            if (m_gnt >= 0 && req[m_gnt] && lock[m_gnt] && m_run < ML) begin
                g  = m_gnt;
                lk = 1'b1;
            end else begin
                for (int i = 1; i <= N; i++) begin
                    idx = (m_last + i) % N;
                    if (g < 0 && req[idx]) g = idx;
                end
            end
            m_gnt <= g;
            if (g >= 0) begin
                m_last <= g;
                m_addr <= int'(req_addr[g*AW +: AW]);
                m_run  <= lk ? m_run + 1 : 1;
            end else begin
                m_run <= 0;
            end
            mp[0] <= '{m_gnt, m_addr};
            for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("gnt", gnt, oh(m_gnt));
            check("buf_rd_addr", buf_rd_addr, m_addr);
            check("rd_valid", rd_valid, oh(mp[L-1].who));
            check("busy", busy, (m_gnt >= 0 || mp[0].who >= 0 || mp[1].who >= 0 ||
                                 mp[2].who >= 0) ? 1 : 0);
            if (mp[L-1].who >= 0) check("rd_data", rd_data, f(mp[L-1].addr));
        end
    end

    task automatic set_addr(input int k, input int v);
        req_addr[k*AW +: AW] = AW'(v);
    endtask

    // Called just after a falling edge; asserts reset mid-cycle and releases on a falling edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_addr", buf_rd_addr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int fair_exp [6]  = '{0, 1, 2, 3, 0, 1};
    int lock_exp [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
    int n0, n2, r0, r2;

    initial begin
        repeat (2) @(negedge clk);
        check("init_gnt", gnt, 0);
        check("init_busy", busy, 0);
        check("init_addr", buf_rd_addr, 0);
        rst_n = 1'b1;

        // Single read from requester 2
        set_addr(2, 1234);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        check("s1_gnt", gnt, 4'b0100);
        check("s1_addr", buf_rd_addr, 1234);
        repeat (3) @(negedge clk);
        check("s1_rd_valid", rd_valid, 4'b0100);
        check("s1_rd_data", rd_data, -1298);
        @(negedge clk);
        check("s1_busy_low", busy, 0);

        // Requester 1 drops its request before it is reached
        req = 4'b0011;
        @(negedge clk);
        req = '0;
        check("drop_gnt0", gnt, 4'b0001);
        @(negedge clk);
        check("drop_gnt_none", gnt, 0);

        // Round-robin fairness from reset
        for (int k = 0; k < N; k++) set_addr(k, 100 * k + k);
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("fair_order", oh2i(gnt), fair_exp[i]);
        end
        req = '0;

        // Lock cap
        @(negedge clk);
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            check("lock_order", oh2i(gnt), lock_exp[i]);
        end
        req  = '0;
        lock = '0;
        repeat (5) @(negedge clk);

        // Idle hold after a grant at address 77
        set_addr(0, 77);
        req = 4'b0001;
        @(negedge clk);
        req = '0;
        check("idle_gnt", gnt, 4'b0001);
        check("idle_addr", buf_rd_addr, 77);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_gnt0", gnt, 0);
            check("idle_addr_hold", buf_rd_addr, 77);
            check("idle_busy", busy, 1);
        end
        @(negedge clk);
        check("idle_busy_low", busy, 0);
        check("idle_addr_final", buf_rd_addr, 77);

        // Reset while three reads are in flight
        req = 4'b1111;
        repeat (3) @(negedge clk);
        req = '0;
        check("mid_busy_before", busy, 1);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_no_valid", rd_valid, 0);
        end
        set_addr(3, 4321);
        req = 4'b1000;
        @(negedge clk);
        req = '0;
        check("mid_resume_gnt", gnt, 4'b1000);
        check("mid_resume_addr", buf_rd_addr, 4321);
        repeat (5) @(negedge clk);

        // Two requesters, eight reads each, collected in order
        n0 = 0; n2 = 0; r0 = 0; r2 = 0;
        for (int c = 0; c < 100; c++) begin
            req[0] = (n0 < 8);
            req[2] = (n2 < 8);
            set_addr(0, 1000 + n0);
            set_addr(2, 2000 + n2);
            @(negedge clk);
            if (gnt[0]) n0++;
            if (gnt[2]) n2++;
            if (rd_valid[0]) begin
                check("pipe_data0", rd_data, f(1000 + r0));
                r0++;
            end
            if (rd_valid[2]) begin
                check("pipe_data2", rd_data, f(2000 + r2));
                r2++;
            end
            if (r0 + r2 == 16) break;
        end
        req = '0;
        check("pipe_total", r0 + r2, 16);
        check("pipe_r0", r0, 8);
        check("pipe_r2", r2, 8);
        repeat (6) @(negedge clk);
        check("end_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/buffer_read_arbiter.md
BUFFER_READ_ARBITER -- requirements
Module: buffer_read_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of classifier requesters sharing the integral-image buffer read port.
REQ-002 Parameter ADDR_W, default 15: buffer address width.
REQ-003 Parameter DATA_W, default 21: signed integral-image data width.
REQ-004 Parameter RD_LATENCY, default 3: cycles from buf_rd_addr update to valid buf_rd_data.
REQ-005 Parameter MAX_LOCK, default 8: maximum consecutive grants to one locked requester.
REQ-006 clk  in  1  single clock; all state updates on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 req  in  N_REQ  per-requester read request; level, one read per grant.
REQ-009 lock  in  N_REQ  per-requester burst-hold request, qualified by req.
REQ-010 req_addr  in  N_REQ*ADDR_W  flattened addresses; requester k at bits [k*ADDR_W +: ADDR_W].
REQ-011 gnt  out  N_REQ  registered one-hot grant; high one cycle per accepted read.
REQ-012 buf_rd_addr  out  ADDR_W  registered address to buffer.
REQ-013 buf_rd_data  in  DATA_W signed  buffer read data.
REQ-014 rd_data  out  DATA_W signed  returned data, equal to buf_rd_data.
REQ-015 rd_valid  out  N_REQ  one-hot; marks the requester owning rd_data this cycle.
REQ-016 busy  out  1  high while any grant or read is in flight.

Function
REQ-017 Each cycle, the block SHALL select at most one requester with req high and register gnt and buf_rd_addr at the next edge.
REQ-018 With no lock in effect, selection SHALL be round-robin: priority starts at (last granted index + 1) mod N_REQ and ascends with wrap.
REQ-019 After reset, the last granted index SHALL be N_REQ-1, so requester 0 has highest priority.
REQ-020 Lock in effect: previous cycle granted k, and req[k] and lock[k] are both high now; k SHALL be granted again regardless of other requests.
REQ-021 A lock counter SHALL count consecutive locked grants. When it reaches MAX_LOCK, the next selection SHALL ignore lock[k] and use round-robin starting at k+1.
REQ-022 The lock counter SHALL reset to 0 on any non-locked grant or idle cycle.
REQ-023 If no req bit is high, gnt SHALL be 0 and buf_rd_addr SHALL hold its previous value.
REQ-024 A tag pipeline of RD_LATENCY stages SHALL shift the registered gnt each cycle; rd_valid SHALL equal the last stage.
REQ-025 Read latency: a grant registered at edge t SHALL yield rd_valid high for cycle t+RD_LATENCY, with rd_data equal to buf_rd_data in that cycle.
REQ-026 Back-to-back grants SHALL be accepted every cycle; throughput is one read per clock and rd_valid may be high on consecutive cycles.
REQ-027 A requester dropping req before being granted SHALL receive no grant and no rd_valid.
REQ-028 busy SHALL be the OR of gnt and all tag-pipeline stages.
REQ-029 Grant and rd_valid for different requesters in the same cycle are legal and independent.

Reset
REQ-030 On rst low, immediately and without waiting for clk: gnt=0, rd_valid=0, busy=0, buf_rd_addr=0, tag pipeline cleared, lock counter=0, last granted index=N_REQ-1.
REQ-031 Reads in flight when reset asserts SHALL be discarded; no rd_valid for them after reset releases.
REQ-032 Grants SHALL resume on the first rising edge after rst deasserts.

Verification
REQ-033 Single read: req=4'b0100, addr2=15'd1234 for one cycle -> gnt=4'b0100 next cycle, buf_rd_addr=1234; rd_valid=4'b0100 three cycles later with rd_data equal to model data.
REQ-034 Fairness: req=4'b1111 held, no lock -> grant order 0,1,2,3,0,1 on consecutive cycles.
REQ-035 Lock cap: req=4'b0011, lock=4'b0001 held -> eight consecutive grants to 0, then one grant to 1, then locking of 0 resumes.
REQ-036 Idle hold: req=0 after a grant at addr 77 -> gnt=0, buf_rd_addr stays 77, busy drops 4 cycles after the last grant.
REQ-037 Reset mid-burst: rst low while 3 reads are in flight -> all outputs 0 asynchronously; no rd_valid after release; the next req=4'b1000 is granted.
REQ-038 Pipelined collection: two requesters each issue 8 reads interleaved -> 16 rd_valid pulses, each tagged correctly, in address order per requester.
